// File: rtl/vdma_rd_burst_ctrl.sv
// VDMA read-side burst sequencer: splits a frame read into AXI4 INCR bursts,
// arbitrates each burst through the write/read lock and gates RREADY.
module vdma_rd_burst_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_W     = 24
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  total_beats,
  input  logic [CNT_W-1:0]  fifo_space,
  input  logic              pend_rd,
  output logic              rd_req,
  output logic              rd_done,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BPB    = DATA_W / 8;
  localparam int unsigned BLEN_W = 9;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_WAIT_GNT = 3'd3;
  localparam logic [2:0] S_ADDR     = 3'd4;
  localparam logic [2:0] S_DATA     = 3'd5;
  localparam logic [2:0] S_NEXT     = 3'd6;

  logic [2:0]        r_state,      w_state_nxt;
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  logic [CNT_W-1:0]  r_left,       w_left_nxt;
  logic [BLEN_W-1:0] r_blen,       w_blen_nxt;
  logic [ADDR_W-1:0] r_araddr,     w_araddr_nxt;
  logic [7:0]        r_arlen,      w_arlen_nxt;
  logic              r_arvalid,    w_arvalid_nxt;
  logic              r_rready,     w_rready_nxt;
  logic              r_rd_req,     w_rd_req_nxt;
  logic              r_rd_done,    w_rd_done_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_frame_done, w_frame_done_nxt;

  logic [BLEN_W-1:0] w_blen_calc;
  logic [ADDR_W-1:0] w_burst_bytes;
  logic              w_beat;

  // Burst length is the full BURST_LEN unless the frame tail is shorter.
  assign w_blen_calc   = (r_left >= CNT_W'(BURST_LEN)) ? BLEN_W'(BURST_LEN)
                                                       : BLEN_W'(r_left);
  assign w_burst_bytes = ADDR_W'(32'(r_blen) * BPB);
  assign w_beat        = r_rready & rvalid;

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_left_nxt       = r_left;
    w_blen_nxt       = r_blen;
    w_araddr_nxt     = r_araddr;
    w_arlen_nxt      = r_arlen;
    w_rd_done_nxt    = 1'b0;
    w_frame_done_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_addr_nxt = base_addr;
          w_left_nxt = total_beats;
          if (total_beats == '0) begin
            w_frame_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        w_blen_nxt = w_blen_calc;
        if (fifo_space >= CNT_W'(w_blen_calc)) begin
          w_state_nxt = S_REQ;
        end
      end
      // pend_rd lags rd_req by a cycle in the lock, so REQ never samples it.
      S_REQ: begin
        w_state_nxt = S_WAIT_GNT;
      end
      S_WAIT_GNT: begin
        if (!pend_rd) begin
          w_state_nxt  = S_ADDR;
          w_araddr_nxt = r_addr;
          w_arlen_nxt  = 8'(r_blen - BLEN_W'(1));
        end
      end
      S_ADDR: begin
        if (r_arvalid && arready) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_beat) begin
          if (r_left != '0) begin
            w_left_nxt = r_left - CNT_W'(1);
          end
          if (rlast) begin
            w_rd_done_nxt = 1'b1;
            w_addr_nxt    = r_addr + w_burst_bytes;
            w_state_nxt   = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (r_left == '0) begin
          w_frame_done_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_rd_req_nxt  = (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT_GNT) ||
                    (w_state_nxt == S_ADDR) || (w_state_nxt == S_DATA);
    w_arvalid_nxt = (w_state_nxt == S_ADDR);
    w_rready_nxt  = (w_state_nxt == S_DATA);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_left       <= '0;
      r_blen       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_rd_req     <= 1'b0;
      r_rd_done    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_left       <= w_left_nxt;
      r_blen       <= w_blen_nxt;
      r_araddr     <= w_araddr_nxt;
      r_arlen      <= w_arlen_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
      r_rd_req     <= w_rd_req_nxt;
      r_rd_done    <= w_rd_done_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign rd_req     = r_rd_req;
  assign rd_done    = r_rd_done;
  assign araddr     = r_araddr;
  assign arlen      = r_arlen;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_vdma_rd_burst_ctrl.sv
// Directed bench for vdma_rd_burst_ctrl: inputs driven and outputs checked
// on the falling clock edge, acting as AXI slave and lock.
module tb_vdma_rd_burst_ctrl;

  logic        clock;
  logic        rst_n;
  logic        frame_start;
  logic [31:0] base_addr;
  logic [23:0] total_beats;
  logic [23:0] fifo_space;
  logic        pend_rd;
  logic        rd_req;
  logic        rd_done;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic        busy;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;
  int n_beats = 0;
  int n_rd_done = 0;
  int n_frame_done = 0;
  int n_req_cyc = 0;
  int n_arv_cyc = 0;

  vdma_rd_burst_ctrl #(
    .ADDR_W(32), .DATA_W(256), .BURST_LEN(16), .CNT_W(24)
  ) dut (
    .clock(clock), .rst_n(rst_n), .frame_start(frame_start),
    .base_addr(base_addr), .total_beats(total_beats), .fifo_space(fifo_space),
    .pend_rd(pend_rd), .rd_req(rd_req), .rd_done(rd_done), .araddr(araddr),
    .arlen(arlen), .arvalid(arvalid), .arready(arready), .rvalid(rvalid),
    .rlast(rlast), .rready(rready), .busy(busy), .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Beat handshakes counted on the edge where they are taken.
  always @(posedge clock) if (rvalid && rready) n_beats++;

  always @(negedge clock) begin
    if (rd_done) n_rd_done++;
    if (frame_done) n_frame_done++;
    if (rd_req) n_req_cyc++;
    if (arvalid) n_arv_cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_req"},     64'(rd_req),     64'd0);
    chk({tag, "_rd_done"},    64'(rd_done),    64'd0);
    chk({tag, "_araddr"},     64'(araddr),     64'd0);
    chk({tag, "_arlen"},      64'(arlen),      64'd0);
    chk({tag, "_arvalid"},    64'(arvalid),    64'd0);
    chk({tag, "_rready"},     64'(rready),     64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
  endtask

  task automatic start_frame(input logic [31:0] addr, input logic [23:0] beats);
    base_addr   = addr;
    total_beats = beats;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic wait_arvalid(input string tag);
    int n = 0;
    while (arvalid !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_arvalid_wait"}, 64'(arvalid), 64'd1);
  endtask

  task automatic wait_rd_req(input string tag);
    int n = 0;
    while (rd_req !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_rd_req_wait"}, 64'(rd_req), 64'd1);
  endtask

  // Serves one burst as AXI slave; returns on the cycle after the NEXT state.
  task automatic do_burst(input logic [31:0] exp_addr, input logic [7:0] exp_len,
                          input int stall, input bit gap, input string tag);
    int b0;
    wait_arvalid(tag);
    chk({tag, "_araddr"}, 64'(araddr), 64'(exp_addr));
    chk({tag, "_arlen"},  64'(arlen),  64'(exp_len));
    chk({tag, "_rd_req"}, 64'(rd_req), 64'd1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      chk({tag, "_stall_arvalid"}, 64'(arvalid), 64'd1);
      chk({tag, "_stall_araddr"},  64'(araddr),  64'(exp_addr));
      chk({tag, "_stall_arlen"},   64'(arlen),   64'(exp_len));
    end
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    chk({tag, "_arvalid_drop"}, 64'(arvalid), 64'd0);
    chk({tag, "_rready"},       64'(rready),  64'd1);
    b0 = n_beats;
    for (int i = 0; i <= int'(exp_len); i++) begin
      if (gap && (i % 4 == 2)) begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        @(negedge clock);
        chk({tag, "_gap_rd_done"}, 64'(rd_done), 64'd0);
        chk({tag, "_gap_rready"},  64'(rready),  64'd1);
      end
      rvalid = 1'b1;
      rlast  = (i == int'(exp_len));
      @(negedge clock);
      if (i != int'(exp_len)) chk({tag, "_mid_rd_done"}, 64'(rd_done), 64'd0);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk({tag, "_rd_done"},      64'(rd_done), 64'd1);
    chk({tag, "_rd_req_drop"},  64'(rd_req),  64'd0);
    chk({tag, "_rready_drop"},  64'(rready),  64'd0);
    chk({tag, "_beats"},        64'(n_beats - b0), 64'(int'(exp_len) + 1));
    @(negedge clock);
    chk({tag, "_rd_done_pulse"}, 64'(rd_done), 64'd0);
  endtask

  initial begin
    int c_done, c_fdone, c_req, c_arv;
    rst_n = 1'b0; frame_start = 1'b0; base_addr = '0; total_beats = '0;
    fifo_space = 24'd64; pend_rd = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    repeat (2) @(negedge clock);
    chk_all_zero("rst_held");
    rst_n = 1'b1;
    @(negedge clock);
    chk_all_zero("rst_idle");

    // Three bursts: 16 + 16 + 8 beats.
    c_done = n_rd_done; c_fdone = n_frame_done;
    start_frame(32'h1000_0000, 24'd40);
    chk("f1_busy", 64'(busy), 64'd1);
    do_burst(32'h1000_0000, 8'd15, 0, 1'b0, "f1_b0");
    chk("f1_b0_no_fdone", 64'(frame_done), 64'd0);
    do_burst(32'h1000_0200, 8'd15, 0, 1'b0, "f1_b1");
    do_burst(32'h1000_0400, 8'd7,  0, 1'b0, "f1_b2");
    chk("f1_frame_done", 64'(frame_done), 64'd1);
    chk("f1_busy_low",   64'(busy),       64'd0);
    @(negedge clock);
    chk("f1_frame_done_pulse", 64'(frame_done), 64'd0);
    chk("f1_rd_done_cnt",  64'(n_rd_done - c_done),     64'd3);
    chk("f1_fdone_cnt",    64'(n_frame_done - c_fdone), 64'd1);

    // Lock holds the read off for 10 cycles.
    pend_rd = 1'b1;
    start_frame(32'h1100_0000, 24'd16);
    wait_rd_req("f2");
    for (int k = 0; k < 10; k++) begin
      chk("f2_held_rd_req",  64'(rd_req),  64'd1);
      chk("f2_held_arvalid", 64'(arvalid), 64'd0);
      @(negedge clock);
    end
    pend_rd = 1'b0;
    @(negedge clock);
    chk("f2_arvalid_after_grant", 64'(arvalid), 64'd1);
    do_burst(32'h1100_0000, 8'd15, 0, 1'b0, "f2_b0");
    chk("f2_frame_done", 64'(frame_done), 64'd1);
    @(negedge clock);

    // FIFO too full: stall in CHECK until space appears.
    fifo_space = 24'd8;
    start_frame(32'h2000_0000, 24'd16);
    for (int k = 0; k < 6; k++) begin
      chk("f3_stall_rd_req", 64'(rd_req), 64'd0);
      chk("f3_stall_busy",   64'(busy),   64'd1);
      @(negedge clock);
    end
    fifo_space = 24'd16;
    @(negedge clock);
    chk("f3_rd_req_rise", 64'(rd_req), 64'd1);
    do_burst(32'h2000_0000, 8'd15, 0, 1'b0, "f3_b0");
    chk("f3_frame_done", 64'(frame_done), 64'd1);
    @(negedge clock);
    fifo_space = 24'd64;

    // Empty frame: done pulse only, no bus activity.
    c_req = n_req_cyc; c_arv = n_arv_cyc;
    start_frame(32'h2800_0000, 24'd0);
    chk("f4_frame_done", 64'(frame_done), 64'd1);
    chk("f4_busy",       64'(busy),       64'd0);
    @(negedge clock);
    chk("f4_frame_done_pulse", 64'(frame_done), 64'd0);
    repeat (3) @(negedge clock);
    chk("f4_no_rd_req",  64'(n_req_cyc - c_req), 64'd0);
    chk("f4_no_arvalid", 64'(n_arv_cyc - c_arv), 64'd0);

    // Ignored restart, AR stall and R gaps.
    c_done = n_rd_done;
    start_frame(32'h3000_0000, 24'd16);
    start_frame(32'h4000_0000, 24'd5);
    do_burst(32'h3000_0000, 8'd15, 5, 1'b1, "f5_b0");
    chk("f5_frame_done", 64'(frame_done), 64'd1);
    chk("f5_busy_low",   64'(busy),       64'd0);
    repeat (4) @(negedge clock);
    chk("f5_idle_rd_req",  64'(rd_req), 64'd0);
    chk("f5_rd_done_cnt",  64'(n_rd_done - c_done), 64'd1);

    // Asynchronous reset in the middle of a data burst.
    start_frame(32'h5000_0000, 24'd16);
    wait_arvalid("f6");
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    rvalid  = 1'b1;
    repeat (3) @(negedge clock);
    chk("f6_in_data_rready", 64'(rready), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("f6_async_rst");
    rvalid = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk_all_zero("f6_post_rst");
    start_frame(32'h6000_0000, 24'd20);
    do_burst(32'h6000_0000, 8'd15, 0, 1'b0, "f6_b0");
    do_burst(32'h6000_0200, 8'd3,  0, 1'b0, "f6_b1");
    chk("f6_frame_done", 64'(frame_done), 64'd1);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
